// File: rtl/cache_sim_pkg.sv
// Shared constants, types and helpers for the L1/L2 cache simulator front end.
package cache_sim_pkg;

  localparam int COUNT_W            = 20;
  localparam int L1_WAY_DEF         = 2;
  localparam int L1_BLOCK_BYTE_DEF  = 16;
  localparam int L1_CACHE_BYTE_DEF  = 16384;
  localparam int L2_WAY_DEF         = 8;
  localparam int L2_BLOCK_BYTE_DEF  = 16;
  localparam int L2_CACHE_BYTE_DEF  = 262144;
  localparam int TIMEOUT_DEF        = 1023;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    L1_START = 3'd1,
    L1_WAIT  = 3'd2,
    L1_UPD   = 3'd3,
    L2_START = 3'd4,
    L2_WAIT  = 3'd5
  } seq_state_e;

  // Ceiling log2; exact for the power-of-two geometries used here.
  function automatic int log2c(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_access_sequencer.sv
// Sequences one trace address at a time through L1 then L2, forwarding L2
// evictions to L1 as a deferred back-invalidation and keeping statistics.
module cache_access_sequencer
  import cache_sim_pkg::*;
#(
  parameter int L1_WAY             = L1_WAY_DEF,
  parameter int L1_BLOCK_SIZE_BYTE = L1_BLOCK_BYTE_DEF,
  parameter int L1_CACHE_SIZE_BYTE = L1_CACHE_BYTE_DEF,
  parameter int L2_WAY             = L2_WAY_DEF,
  parameter int L2_BLOCK_SIZE_BYTE = L2_BLOCK_BYTE_DEF,
  parameter int L2_CACHE_SIZE_BYTE = L2_CACHE_BYTE_DEF,
  parameter int TIMEOUT_CYCLES     = TIMEOUT_DEF,
  localparam int L1_OFF_IDX = log2c(L1_BLOCK_SIZE_BYTE),
  localparam int L1_SET_IDX = log2c(L1_CACHE_SIZE_BYTE / (L1_BLOCK_SIZE_BYTE * L1_WAY)),
  localparam int L2_OFF_IDX = log2c(L2_BLOCK_SIZE_BYTE),
  localparam int L2_SET_IDX = log2c(L2_CACHE_SIZE_BYTE / (L2_BLOCK_SIZE_BYTE * L2_WAY))
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             addr_valid,
  input  logic [31:0]                      addr_in,
  output logic                             addr_ready,
  output logic [31-L1_SET_IDX-L1_OFF_IDX:0] l1_tag,
  output logic [L1_SET_IDX-1:0]            l1_index,
  output logic [L1_OFF_IDX-1:0]            l1_block_offset,
  output logic                             l1_find_start,
  input  logic                             l1_done,
  input  logic                             l1_found,
  input  logic                             l1_updated,
  output logic                             l1_back_invalidation,
  output logic [31:0]                      l1_back_invalidation_data,
  output logic [31-L2_SET_IDX-L2_OFF_IDX:0] l2_tag,
  output logic [L2_SET_IDX-1:0]            l2_index,
  output logic [L2_OFF_IDX-1:0]            l2_block_offset,
  output logic                             l2_find_start,
  input  logic                             l2_done,
  input  logic                             l2_hit,
  input  logic                             l2_evict_valid,
  input  logic [31:0]                      l2_evict_addr,
  output logic [COUNT_W-1:0]               access_count,
  output logic [COUNT_W-1:0]               l1_miss_count,
  output logic [COUNT_W-1:0]               l2_miss_count,
  output logic                             busy,
  output logic                             timeout_err
);

  localparam int TO_W = log2c(TIMEOUT_CYCLES + 1) + 1;

  seq_state_e                        state_q;
  logic [31-L1_SET_IDX-L1_OFF_IDX:0] l1_tag_q;
  logic [L1_SET_IDX-1:0]             l1_index_q;
  logic [L1_OFF_IDX-1:0]             l1_off_q;
  logic [31-L2_SET_IDX-L2_OFF_IDX:0] l2_tag_q;
  logic [L2_SET_IDX-1:0]             l2_index_q;
  logic [L2_OFF_IDX-1:0]             l2_off_q;
  logic                              l1_find_q;
  logic                              l2_find_q;
  logic                              binv_q;
  logic [31:0]                       binv_dat_q;
  logic                              pend_vld_q;
  logic [31:0]                       pend_addr_q;
  logic                              found_q;
  logic [TO_W-1:0]                   wait_cnt_q;
  logic                              timeout_q;

  logic to_hit;
  logic acc_inc, l1m_inc, l2m_inc;

  // Fires on the last permitted waiting cycle, so a stalled handshake
  // spends exactly TIMEOUT_CYCLES cycles in its wait state.
  assign to_hit = (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      l1_tag_q    <= '0;
      l1_index_q  <= '0;
      l1_off_q    <= '0;
      l2_tag_q    <= '0;
      l2_index_q  <= '0;
      l2_off_q    <= '0;
      l1_find_q   <= 1'b0;
      l2_find_q   <= 1'b0;
      binv_q      <= 1'b0;
      binv_dat_q  <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      found_q     <= 1'b0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      l1_find_q  <= 1'b0;
      l2_find_q  <= 1'b0;
      binv_q     <= 1'b0;
      binv_dat_q <= '0;
      case (state_q)
        IDLE: begin
          if (addr_valid) begin
            l1_tag_q   <= addr_in[31:L1_SET_IDX+L1_OFF_IDX];
            l1_index_q <= addr_in[L1_SET_IDX+L1_OFF_IDX-1:L1_OFF_IDX];
            l1_off_q   <= addr_in[L1_OFF_IDX-1:0];
            l2_tag_q   <= addr_in[31:L2_SET_IDX+L2_OFF_IDX];
            l2_index_q <= addr_in[L2_SET_IDX+L2_OFF_IDX-1:L2_OFF_IDX];
            l2_off_q   <= addr_in[L2_OFF_IDX-1:0];
            l1_find_q  <= 1'b1;
            binv_q     <= pend_vld_q;
            binv_dat_q <= pend_vld_q ? pend_addr_q : 32'd0;
            wait_cnt_q <= '0;
            state_q    <= L1_START;
          end
        end
        L1_START: begin
          wait_cnt_q <= '0;
          state_q    <= L1_WAIT;
        end
        L1_WAIT: begin
          if (l1_done) begin
            found_q    <= l1_found;
            wait_cnt_q <= '0;
            state_q    <= L1_UPD;
          end else if (to_hit) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        L1_UPD: begin
          if (l1_updated) begin
            pend_vld_q <= 1'b0;
            wait_cnt_q <= '0;
            l2_find_q  <= !found_q;
            state_q    <= found_q ? IDLE : L2_START;
          end else if (to_hit) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        L2_START: begin
          wait_cnt_q <= '0;
          state_q    <= L2_WAIT;
        end
        L2_WAIT: begin
          if (l2_done) begin
            if (l2_evict_valid) begin
              pend_vld_q  <= 1'b1;
              pend_addr_q <= l2_evict_addr;
            end
            state_q <= IDLE;
          end else if (to_hit) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign acc_inc = (state_q == IDLE) && addr_valid && !rst;
  assign l1m_inc = (state_q == L1_UPD) && l1_updated && !found_q;
  assign l2m_inc = (state_q == L2_WAIT) && l2_done && !l2_hit;

  sat_counter #(.WIDTH(COUNT_W)) u_acc_cnt (
    .clk(clk), .rst(rst), .inc(acc_inc), .count(access_count)
  );
  sat_counter #(.WIDTH(COUNT_W)) u_l1m_cnt (
    .clk(clk), .rst(rst), .inc(l1m_inc), .count(l1_miss_count)
  );
  sat_counter #(.WIDTH(COUNT_W)) u_l2m_cnt (
    .clk(clk), .rst(rst), .inc(l2m_inc), .count(l2_miss_count)
  );

  assign addr_ready                = (state_q == IDLE) && !rst;
  assign busy                      = (state_q != IDLE);
  assign l1_tag                    = l1_tag_q;
  assign l1_index                  = l1_index_q;
  assign l1_block_offset           = l1_off_q;
  assign l2_tag                    = l2_tag_q;
  assign l2_index                  = l2_index_q;
  assign l2_block_offset           = l2_off_q;
  assign l1_find_start             = l1_find_q;
  assign l2_find_start             = l2_find_q;
  assign l1_back_invalidation      = binv_q;
  assign l1_back_invalidation_data = binv_dat_q;
  assign timeout_err               = timeout_q;

endmodule

// File: doc/cache_access_sequencer.md
Name: cache_access_sequencer

Overview:
- Front end of the L1/L2 simulator. Accepts 32-bit byte addresses from a trace source over a valid/ready handshake.
- Splits each address into tag, index and offset, then runs one access at a time: L1 lookup and update first, then an L2 lookup on an L1 miss.
- Forwards L2 back-invalidation information to L1. Keeps 20-bit access and miss statistics.

Parameters:
- L1_WAY, 2, L1 associativity (power of 2)
- L1_BLOCK_SIZE_BYTE, 16, L1 line size
- L1_CACHE_SIZE_BYTE, 16384, L1 capacity
- L2_WAY, 8, L2 associativity
- L2_BLOCK_SIZE_BYTE, 16, L2 line size
- L2_CACHE_SIZE_BYTE, 262144, L2 capacity
- TIMEOUT_CYCLES, 1023, maximum cycles spent waiting on any cache handshake before an error is flagged

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- addr_valid  in  1  trace address available
- addr_in  in  32  byte address
- addr_ready  out  1  sequencer can accept an address
- l1_tag  out  32-L1_SET_IDX-L1_OFF_IDX  L1 tag
- l1_index  out  L1_SET_IDX  L1 set
- l1_block_offset  out  L1_OFF_IDX  L1 offset
- l1_find_start  out  1  L1 lookup start
- l1_done  in  1  L1 lookup finished
- l1_found  in  1  L1 hit, valid with l1_done
- l1_updated  in  1  L1 replacement/LRU update complete
- l1_back_invalidation  out  1  back-invalidation request to L1
- l1_back_invalidation_data  out  32  address to invalidate in L1
- l2_tag / l2_index / l2_block_offset  out  (L2 widths)  L2 address fields
- l2_find_start  out  1  L2 lookup start
- l2_done  in  1  L2 access complete (lookup and update)
- l2_hit  in  1  L2 hit, valid with l2_done
- l2_evict_valid  in  1  L2 evicted a valid line, valid with l2_done
- l2_evict_addr  in  32  evicted line address
- access_count  out  20  accepted accesses
- l1_miss_count  out  20  L1 misses
- l2_miss_count  out  20  L2 misses
- busy  out  1  access in flight
- timeout_err  out  1  sticky handshake timeout

Behaviour:
- Derived constants:
  - L1_OFF_IDX = log2(L1_BLOCK_SIZE_BYTE); L1_SET_IDX = log2(L1_CACHE_SIZE_BYTE/(L1_BLOCK_SIZE_BYTE*L1_WAY)).
  - L2_OFF_IDX and L2_SET_IDX are derived the same way from the L2 parameters.
- Address split: tag = addr[31:SET+OFF], index = addr[SET+OFF-1:OFF], offset = addr[OFF-1:0]. Fields are registered at accept and held stable until the access returns to IDLE.
- Reset: all outputs are 0 and the FSM enters IDLE. A reset mid-access aborts the access, drops any pending back-invalidation and clears counters and timeout_err. addr_ready is 0 during reset.
- FSM:
  - IDLE: addr_ready=1. Accept on addr_valid&&addr_ready, increment access_count, go to L1_START.
  - L1_START: l1_find_start=1 for exactly one cycle. Present any pending back-invalidation on l1_back_invalidation/data. Go to L1_WAIT.
  - L1_WAIT: on l1_done, latch l1_found and go to L1_UPD.
  - L1_UPD: wait for l1_updated. Once it arrives:
    - Clear the pending back-invalidation; L1 has consumed it.
    - If the latched result is a hit, go to IDLE.
    - If it is a miss, increment l1_miss_count and go to L2_START.
  - L2_START: l2_find_start=1 for one cycle, then go to L2_WAIT.
  - L2_WAIT: on l2_done, increment l2_miss_count if !l2_hit. If l2_evict_valid, latch l2_evict_addr as the pending back-invalidation. Go to IDLE.
- Back-invalidation is deferred: it is delivered with the next L1 access and is not applied to the current one.
  - A second eviction arriving while one is still pending overwrites it. This cannot happen in normal flow.
- busy = (state != IDLE). addr_ready = (state == IDLE) && !rst.
- Timeout:
  - A wait counter resets on each state entry and increments in L1_WAIT, L1_UPD and L2_WAIT.
  - On reaching TIMEOUT_CYCLES, set timeout_err (sticky until reset) and return to IDLE. Counters keep their values.
- Counters are 20 bits and saturate at 20'hFFFFF; they never wrap.
- l1_done and l1_updated are ignored outside their wait states.

Decomposition:
- Package cache_sim_pkg:
  - log2 helper function; L1/L2 default size constants.
  - FSM state enum: IDLE, L1_START, L1_WAIT, L1_UPD, L2_START, L2_WAIT.
  - COUNT_W = 20.
- Sub-module sat_counter (parameter width; inputs clk, rst, inc; output count). Instantiated three times for the statistics.

Test Plan:
- Reset then present addr 0x0000_1230. Respond with L1 miss and L2 miss, no eviction.
  - Required: l1_tag=0x00000, l1_index=0x123, l1_block_offset=0x0.
  - Required: access_count=1, l1_miss_count=1, l2_miss_count=1, single-cycle find_start pulses.
- Same address again, L1 hit -> no l2_find_start; l1_miss_count remains 1; addr_ready returns one cycle after l1_updated.
- L1 miss, L2 miss with l2_evict_valid=1 and l2_evict_addr=0xDEAD_BEE0.
  - Next access: l1_back_invalidation=1 and data=0xDEAD_BEE0 during L1_START.
  - After that access's l1_updated, l1_back_invalidation=0.
- Hold l1_done low for TIMEOUT_CYCLES -> timeout_err=1, busy=0, addr_ready=1; stays set until rst.
- Assert rst during L2_WAIT with a pending back-invalidation -> next cycle all counters are 0, the FSM is in IDLE, and the next access presents l1_back_invalidation=0.
- Preload counter stimulus of 2^20+5 L1 misses (forced) -> l1_miss_count holds 0xFFFFF.
